imem_port_arbiter: RTL
======================

Name: imem_port_arbiter

Overview:
Owns the single port of the synchronous instruction memory (64 x 32-bit words, byte-addressed, word index = address >> 2) and shares it between two requesters: the CPU fetch stage and the program loader.
After reset it runs a BOOT phase in which only the loader may write. It then moves to RUN, where fetch has priority and a bounded-wait counter guarantees loader progress.
It also rejects misaligned and out-of-range accesses.

Parameters:
SIZE, 64, memory depth in 32-bit words
MAX_WAIT, 4, consecutive cycles a pending load may lose to fetch in RUN before it is forced to win (>=1)
IDX_W, $clog2(SIZE), width of the word index

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request
fetch_addr  in  32  fetch byte address
fetch_gnt  out  1  fetch accepted this cycle (combinational)
fetch_rvalid  out  1  fetch data valid, one cycle after grant
fetch_rdata  out  32  fetch data, valid with fetch_rvalid
fetch_err  out  1  with fetch_rvalid: access was rejected
load_req  in  1  loader write request
load_addr  in  32  loader byte address
load_wdata  in  32  word to write
load_last  in  1  marks the final word of the boot image
load_gnt  out  1  load accepted this cycle (combinational)
load_err  out  1  one-cycle pulse, one cycle after a rejected granted load
boot_done  out  1  high while in RUN
mem_en  out  1  memory port enable
mem_we  out  1  memory write enable
mem_addr  out  IDX_W  word index
mem_wdata  out  32  write data
mem_rdata  in  32  memory read data, registered, one-cycle latency

Behaviour:
- Handshake: a transfer occurs when req and gnt are both high in the same cycle. A requester must hold addr, data and last stable while req is high and gnt is low.
- At most one grant per cycle.
- Rejection: an access is rejected if addr[1:0] != 0 or (addr >> 2) >= SIZE.
  - A rejected access is still granted (consumed), but mem_en = 0.
  - Rejected fetch: fetch_rvalid = 1, fetch_rdata = 0, fetch_err = 1 on the next cycle.
  - Rejected load: load_err pulses on the next cycle.
- Memory drive: mem_en = 1 for every accepted, in-range access. mem_we = 1 only for loads. mem_addr = addr[IDX_W+1:2]. mem_wdata = load_wdata.
- Fetch response: fetch_rvalid rises exactly one cycle after the accepting edge. It is high for one cycle unless another fetch was accepted (back-to-back). fetch_rdata = mem_rdata; fetch_err = 0 for in-range fetches.
- State BOOT (reset state):
  - fetch_gnt = 0.
  - load_gnt = load_req.
  - An accepted load with load_last = 1 moves the block to RUN, including when that load is rejected.
- State RUN (terminal until reset):
  - Only fetch requesting: fetch wins.
  - Only load requesting: load wins.
  - Both requesting and wait_cnt < MAX_WAIT: fetch wins and wait_cnt increments.
  - Both requesting and wait_cnt == MAX_WAIT: load wins.
  - wait_cnt clears on any load grant or whenever load_req = 0.
  - load_last is ignored in RUN.
- Counter width: $clog2(MAX_WAIT+1). It saturates and never wraps.
- Reset (async, any time, including mid-transfer):
  - state = BOOT, wait_cnt = 0.
  - fetch_rvalid = 0, fetch_err = 0, fetch_rdata = 0, load_err = 0, boot_done = 0.
  - Any outstanding response is dropped.
  - Combinational outputs follow from the reset state: with no requests, gnts and mem_en are 0.
- boot_done is registered and equals (state == RUN).

Decomposition:
- Shared package imem_pkg:
  - state enum {ST_BOOT, ST_RUN}
  - IMEM_SIZE = 64
  - word-index helper constant WORD_SHIFT = 2
- One natural sub-module: imem_addr_check. It is combinational: addr -> {idx, misaligned, out_of_range}. It is instantiated once per requester.
- Arbitration FSM, wait counter and response register stay in the top module.

Test Plan:
1. BOOT load: write 0x20080005 @0x0, 0x20090003 @0x4, then 0x01095020 @0x8 with load_last. Expect three mem_we pulses at idx 0,1,2, and boot_done = 1 on the cycle after the third grant.
2. Fetch during BOOT: fetch_req held high for 3 cycles. Expect fetch_gnt = 0 throughout. After RUN is reached, fetch @0x4 is granted, and the next cycle gives fetch_rvalid = 1 with rdata 0x20090003.
3. Starvation (MAX_WAIT = 4, RUN): fetch_req and load_req held continuously.
   - Expect 4 fetch grants, then 1 load grant, then the pattern repeats.
   - A load_req deassert mid-run resets the count.
4. Errors:
   - Fetch @0x6: fetch_rvalid = 1, fetch_err = 1, rdata = 0, mem_en = 0.
   - Load @0x100 (SIZE = 64): load_err pulse, no mem_we.
5. Back-to-back fetches @0x0, 0x4, 0x8 on consecutive cycles: fetch_rvalid stays high for 3 cycles with data in order.
6. Async reset mid-RUN: assert rst_n = 0 between clock edges while a fetch is outstanding.
   - Expect fetch_rvalid = 0 and boot_done = 0 immediately.
   - After release, state is BOOT and fetch is blocked.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
package imem_pkg;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_t;

  localparam int IMEM_SIZE  = 64;
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/imem_addr_check.sv
// Splits a byte address into a word index and flags accesses that are
// misaligned or fall beyond the end of the instruction memory.
module imem_addr_check
  import imem_pkg::*;
#(
  parameter int SIZE  = IMEM_SIZE,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic [31:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             misaligned,
  output logic             out_of_range
);

  logic [31:0] word;

  assign word         = addr >> WORD_SHIFT;
  assign idx          = addr[IDX_W+WORD_SHIFT-1:WORD_SHIFT];
  assign misaligned   = (addr[WORD_SHIFT-1:0] != '0);
  assign out_of_range = (word >= 32'(SIZE));

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single instruction-memory port between the fetch stage and the
// program loader: loader-only BOOT phase, then fetch-priority RUN phase with a
// bounded wait so a pending load always gets through eventually.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int SIZE     = IMEM_SIZE,
  parameter int MAX_WAIT = 4,
  parameter int IDX_W    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  output logic             fetch_gnt,
  output logic             fetch_rvalid,
  output logic [31:0]      fetch_rdata,
  output logic             fetch_err,
  input  logic             load_req,
  input  logic [31:0]      load_addr,
  input  logic [31:0]      load_wdata,
  input  logic             load_last,
  output logic             load_gnt,
  output logic             load_err,
  output logic             boot_done,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             starved;

  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_mis;
  logic             fetch_oor;
  logic             fetch_ok;
  logic [IDX_W-1:0] load_idx;
  logic             load_mis;
  logic             load_oor;
  logic             load_ok;

  imem_addr_check #(
    .SIZE (SIZE),
    .IDX_W(IDX_W)
  ) u_fetch_check (
    .addr        (fetch_addr),
    .idx         (fetch_idx),
    .misaligned  (fetch_mis),
    .out_of_range(fetch_oor)
  );

  imem_addr_check #(
    .SIZE (SIZE),
    .IDX_W(IDX_W)
  ) u_load_check (
    .addr        (load_addr),
    .idx         (load_idx),
    .misaligned  (load_mis),
    .out_of_range(load_oor)
  );

  assign fetch_ok = !fetch_mis && !fetch_oor;
  assign load_ok  = !load_mis && !load_oor;
  assign starved  = (wait_cnt >= CNT_W'(MAX_WAIT));

  // Pick at most one winner: loader only during boot, fetch first in RUN
  // unless the loader has already lost MAX_WAIT times in a row.
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (state == ST_BOOT) begin
      load_gnt = load_req;
    end else if (fetch_req && load_req) begin
      if (starved) begin
        load_gnt = 1'b1;
      end else begin
        fetch_gnt = 1'b1;
      end
    end else begin
      fetch_gnt = fetch_req;
      load_gnt  = load_req;
    end
  end

  // Drive the memory port from the winner; rejected accesses are consumed
  // without touching the memory.
  always_comb begin
    mem_we    = load_gnt && load_ok;
    mem_en    = mem_we || (fetch_gnt && fetch_ok);
    mem_addr  = load_gnt ? load_idx : fetch_idx;
    mem_wdata = load_wdata;
  end

  // Phase FSM: leave BOOT on the accepted final image word (even if that
  // word was rejected); RUN is held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      boot_done <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (load_gnt && load_last) begin
            state     <= ST_RUN;
            boot_done <= 1'b1;
          end
        end
        ST_RUN: begin
          state     <= ST_RUN;
          boot_done <= 1'b1;
        end
        default: begin
          state     <= ST_BOOT;
          boot_done <= 1'b0;
        end
      endcase
    end
  end

  // Count consecutive losses of a pending load; saturates at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (load_gnt || !load_req) begin
      wait_cnt <= '0;
    end else if (fetch_gnt && !starved) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Response flags for the access accepted on the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_rvalid <= 1'b0;
      fetch_err    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      fetch_rvalid <= fetch_gnt;
      fetch_err    <= fetch_gnt && !fetch_ok;
      load_err     <= load_gnt && !load_ok;
    end
  end

  // Memory data lands in the same cycle as fetch_rvalid; a rejected or
  // absent fetch returns zero.
  assign fetch_rdata = (fetch_rvalid && !fetch_err) ? mem_rdata : 32'h0;

endmodule
